// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive path: FSM encodings,
// default widths and the frame-length helper.
package uart_rx_engine_pkg;

    localparam int K_W_DEF  = 19;
    localparam int SR_W_DEF = 10;
    localparam int K_MIN    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    // Bits captured after the start bit: data, optional parity, stop.
    function automatic logic [3:0] frame_bits(
        input logic eight,
        input logic pen
    );
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_rx_engine_bit_timer.sv
// Loadable down-counter with a zero flag; shared with the tx baud path.
// The counter parks at zero until the next load.
module uart_rx_engine_bit_timer #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (!zero) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit validation, LSB-first deserialise,
// parity/framing/overrun status toward the host register interface.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int K_W  = K_W_DEF,
    parameter int SR_W = SR_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    input  logic [K_W-1:0] k,
    input  logic           eight,
    input  logic           pen,
    input  logic           ohel,
    input  logic           clr,
    output logic [7:0]     data,
    output logic           rxrdy,
    output logic           perr,
    output logic           ferr,
    output logic           ovf,
    output logic           busy
);

    localparam int SH_W = $clog2(SR_W);

    rx_state_t       state, state_nx;
    logic            rx_m, rx_s, rx_d;
    logic            fall, start_ok;
    logic [K_W-1:0]  k_l, tmr_val;
    logic            eight_l, pen_l, ohel_l;
    logic [3:0]      n_l, bit_cnt;
    logic [SR_W-1:0] sr;
    logic            tmr_load, tmr_zero;
    logic            take, shift_en;
    logic [SH_W-1:0] sh;
    logic [7:0]      raw, dat;
    logic            par_b, stop_b, perr_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall     = rx_d & ~rx_s;
    assign start_ok = fall && (k >= K_W'(K_MIN));

    // Loads are one less than the bit time: the reload edge is a tick.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = k_l - K_W'(1);
        take     = 1'b0;
        shift_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = START;
                    tmr_load = 1'b1;
                    tmr_val  = (k >> 1) - K_W'(1);
                    take     = 1'b1;
                end
            end
            START: begin
                if (tmr_zero) begin
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = SHIFT;
                        tmr_load = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (tmr_zero) begin
                    shift_en = 1'b1;
                    tmr_load = 1'b1;
                    if (bit_cnt + 4'd1 == n_l) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    uart_rx_engine_bit_timer #(
        .W(K_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .val (tmr_val),
        .zero(tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_l     <= '0;
            eight_l <= 1'b0;
            pen_l   <= 1'b0;
            ohel_l  <= 1'b0;
            n_l     <= '0;
            bit_cnt <= '0;
            sr      <= '1;
        end else if (take) begin
            k_l     <= k;
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
            n_l     <= frame_bits(eight, pen);
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr      <= {rx_s, sr[SR_W-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // The last N bits shifted in sit at the top of sr, stop bit in the MSB.
    assign sh      = SH_W'(SR_W - int'(n_l));
    assign raw     = sr[sh +: 8];
    assign dat     = eight_l ? raw : {1'b0, raw[6:0]};
    assign par_b   = sr[SR_W-2];
    assign stop_b  = sr[SR_W-1];
    assign perr_nx = pen_l & ((^dat ^ ohel_l) != par_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= 8'h00;
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == DONE) begin
            data  <= dat;
            perr  <= perr_nx;
            ferr  <= ~stop_b;
            ovf   <= ovf | rxrdy;
            rxrdy <= 1'b1;
        end else if (clr) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Serial receive engine for the UART. It samples the asynchronous rx line and detects and validates the start bit. It then de-serializes a 9-11 bit frame, LSB first, made of start, 7/8 data bits, optional parity and stop. It presents the data byte with ready, parity, framing and overrun flags to the host-side register interface. It is the receive counterpart of the transmit shift-register path and sits between the rx pad and the status/data read mux.

Parameters:
K_W, 19, width of bit-time divisor input k
SR_W, 10, receive shift-register width (max bits after start: 8 data + parity + stop)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
k  in  K_W  clocks per bit time; valid range k >= 4
eight  in  1  1 = 8 data bits, 0 = 7 data bits
pen  in  1  parity enable
ohel  in  1  parity sense: 1 = odd, 0 = even
clr  in  1  one-cycle read strobe; clears rxrdy, perr, ferr, ovf
data  out  8  received byte; bit 7 forced 0 in 7-bit mode
rxrdy  out  1  frame complete, data valid
perr  out  1  parity error on last frame
ferr  out  1  framing error (stop bit sampled 0)
ovf  out  1  frame completed while rxrdy still set
busy  out  1  frame reception in progress

Behaviour:
- Reset (rst=0, async): FSM=IDLE; counters 0; shift reg all 1s; synchronizer flops 1; data=0x00; rxrdy=perr=ferr=ovf=busy=0.
- rx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s. This adds 2 cycles of latency.
- k and the config inputs (eight, pen, ohel) are latched on start detection. Changes mid-frame have no effect.
- N = 8 + eight + pen is the number of bits captured after start, so N is 8..10.
- FSM states:
  - IDLE: busy=0. A falling edge on rx_s with k >= 4 loads bit_cnt=0 and time_cnt=k>>1, then goes to START. With k < 4 the FSM stays in IDLE.
  - START: time_cnt counts down to 0, which is mid start bit. If rx_s=0, go to SHIFT with time_cnt=k. If rx_s=1, it is a false start: go back to IDLE with no flag change.
  - SHIFT: when time_cnt reaches 0, shift sr <= {rx_s, sr[SR_W-1:1]}, increment bit_cnt and reload time_cnt=k. When bit_cnt reaches N, go to DONE.
  - DONE (1 cycle): right-justify w = sr >> (SR_W-N).
    - data = w[7:0] if eight=1, else {1'b0, w[6:0]}.
    - Parity bit p = w[N-2] when pen=1. Set perr = pen & ((^data_bits ^ ohel) != p); odd sense means data XOR p = 1.
    - ferr = ~w[N-1].
    - ovf <= rxrdy (sticky until clr).
    - rxrdy <= 1. Go to IDLE.
- Flags and data update only in DONE. Between frames, data holds its value.
- rxrdy rises on the clock edge after the stop-bit sample. Measured from the first clock with rx_s=0, the stop-bit sample occurs at (k>>1) + N*k clocks.
- If clr and DONE occur in the same cycle, DONE wins: the flags take the new frame values. ovf uses rxrdy as it was before that cycle.
- clr while busy has no effect on the frame in progress.
- A low rx that persists (break condition) yields a frame with ferr=1 and data=0x00. The engine returns to IDLE and waits for the next falling edge, so it cannot re-trigger until rx goes high.
- Async reset mid-frame aborts immediately to the reset values. The remainder of the frame is ignored until a new falling edge arrives.

Decomposition:
- Shared header holds:
  - state encodings IDLE/START/SHIFT/DONE (2-bit);
  - K_W and SR_W defaults;
  - the min-k constant (4).
- One natural sub-module is bit_timer: a loadable down-counter with a zero flag. It is reusable by the transmit baud generator.

Test Plan:
- k=16, eight=1, pen=0: send 0xA5 as 8N1 -> data=0xA5, rxrdy=1 at (8+9*16)+1 clocks after rx_s falls; perr=ferr=ovf=0.
- k=16, eight=1, pen=1, ohel=0: send 0x3C with parity bit 0 -> perr=0. Repeat with parity bit 1 -> perr=1, data=0x3C.
- k=16, eight=0, pen=1, ohel=1: send 7-bit 0x41 with parity 1 -> data=0x41, perr=0. Then send with stop=0 -> ferr=1.
- Send two frames of 0x11 and 0x22 with no clr -> data=0x22, ovf=1. Then pulse clr -> rxrdy=perr=ferr=ovf=0.
- Glitch rx low for 3 clocks with k=16 -> false start, back to IDLE, busy falls, no flag change. Separately, assert rst low mid-data -> all outputs 0 immediately, and the next valid frame of 0x5A is received correctly.
- Pulse clr in the exact DONE cycle of frame 0x77 -> rxrdy stays 1 and data=0x77.
